lock_ctrl_fsm: RTL and testbench

Parametrised next-generation controller for the combination-lock datapath. It sequences the input, store and compare phases from the three push-buttons. It counts failed attempts up to a configurable limit and runs an internal lockout timer, so no external end_sleep source is needed. Outputs are glitch-free Moore outputs decoded from the state register. The block drives the code-entry register (input_value), the password store (store_value) and the code checker (compare).

---
 rtl/lock_pkg.sv | 26 ++
 rtl/lock_down_timer.sv | 30 +++
 rtl/lock_ctrl_fsm.sv | 171 +++++++++++++++++
 tb/tb_lock_ctrl_fsm.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared types and constants for the combination-lock controller
package lock_pkg;

   localparam int STATE_W   = 4;
   localparam int ATTEMPT_W = 4;
   localparam int ESC_MAX   = 3;

   typedef enum logic [STATE_W-1:0] {
      IDLE     = 4'd0,
      INPUT    = 4'd1,
      WAIT_IN  = 4'd2,
      COMPARE  = 4'd3,
      RESULT   = 4'd4,
      CHECK    = 4'd5,
      LOCKOUT  = 4'd6,
      STORE    = 4'd7,
      WAIT_ST  = 4'd8,
      STORE_PW = 4'd9
   } lock_state_t;

   // Next escalation level, holding at the cap once reached
   function automatic logic [1:0] esc_next(input logic [1:0] lvl);
      return (lvl == 2'(ESC_MAX)) ? lvl : lvl + 2'd1;
   endfunction

endpackage

// File: rtl/lock_down_timer.sv
// rtl/lock_down_timer.sv - loadable down-counter with zero flag
module lock_down_timer #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             system_reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_value,
   output logic             done
);

   logic [CNT_W-1:0] count;

   // Load has priority; otherwise count down and park at zero
   always_ff @(posedge clk) begin
      if (system_reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   // Zero is the expiry condition seen by the controller
   always_comb begin
      done = (count == '0);
   end

endmodule

// File: rtl/lock_ctrl_fsm.sv
// rtl/lock_ctrl_fsm.sv - lock sequencer with attempt limit and lockout timer (LOCK_ESCALATE_EN doubles lockout per level)
module lock_ctrl_fsm
   import lock_pkg::*;
#(
   parameter int MAX_ATTEMPTS   = 3,
   parameter int LOCKOUT_CYCLES = 50_000_000,
   parameter int CMP_TIMEOUT    = 16,
   parameter int CNT_W          = 32
) (
   input  logic                 clk,
   input  logic                 system_reset,
   input  logic                 input_button,
   input  logic                 store_button,
   input  logic                 submit_button,
   input  logic                 correct_password,
   input  logic                 invalid_password,
   output logic                 input_value,
   output logic                 store_value,
   output logic                 compare,
   output logic                 unlock_pulse,
   output logic                 locked,
   output logic [ATTEMPT_W-1:0] attempts_left
);

   localparam logic [ATTEMPT_W-1:0] MAX_A = ATTEMPT_W'(MAX_ATTEMPTS);

   lock_state_t          state, next_state;
   logic [ATTEMPT_W-1:0] fail_cnt;
   logic                 unlock_q;
   logic                 cmp_load, lock_load;
   logic                 cmp_done, lock_done;
   logic                 fail_event, correct_event;
   logic [CNT_W-1:0]     lock_load_value;

`ifdef LOCK_ESCALATE_EN
   logic [1:0] esc_level;

   // Escalation level rises on every lockout entry, cleared only by a correct password
   always_ff @(posedge clk) begin
      if (system_reset) begin
         esc_level <= 2'd0;
      end else if (correct_event) begin
         esc_level <= 2'd0;
      end else if (lock_load) begin
         esc_level <= esc_next(esc_level);
      end
   end

   // Lockout length doubles per escalation level
   always_comb begin
      lock_load_value = (CNT_W'(LOCKOUT_CYCLES) << esc_level) - CNT_W'(1);
   end
`else
   // Fixed lockout length
   always_comb begin
      lock_load_value = CNT_W'(LOCKOUT_CYCLES - 1);
   end
`endif

   lock_down_timer #(.CNT_W(CNT_W)) u_cmp_timer (
      .clk          (clk),
      .system_reset (system_reset),
      .load         (cmp_load),
      .load_value   (CNT_W'(CMP_TIMEOUT - 1)),
      .done         (cmp_done)
   );

   lock_down_timer #(.CNT_W(CNT_W)) u_lock_timer (
      .clk          (clk),
      .system_reset (system_reset),
      .load         (lock_load),
      .load_value   (lock_load_value),
      .done         (lock_done)
   );

   // State register, fail counter and the one-cycle unlock flag
   always_ff @(posedge clk) begin
      if (system_reset) begin
         state    <= IDLE;
         fail_cnt <= '0;
         unlock_q <= 1'b0;
      end else begin
         state    <= next_state;
         unlock_q <= correct_event;
         if (fail_event) begin
            if (fail_cnt != MAX_A) fail_cnt <= fail_cnt + 1'b1;
         end else if (correct_event) begin
            fail_cnt <= '0;
         end else if (state == LOCKOUT && lock_done) begin
            fail_cnt <= '0;
         end
      end
   end

   // Next-state logic; outputs decode the current state only
   always_comb begin
      next_state    = state;
      cmp_load      = 1'b0;
      lock_load     = 1'b0;
      fail_event    = 1'b0;
      correct_event = 1'b0;
      input_value   = 1'b0;
      store_value   = 1'b0;
      compare       = 1'b0;
      locked        = 1'b0;
      case (state)
         IDLE: begin
            if (input_button)      next_state = INPUT;
            else if (store_button) next_state = STORE;
         end
         INPUT: begin
            input_value = 1'b1;
            if (!input_button) next_state = WAIT_IN;
         end
         WAIT_IN: begin
            if (submit_button)     next_state = COMPARE;
            else if (input_button) next_state = INPUT;
         end
         COMPARE: begin
            compare = 1'b1;
            if (!submit_button) begin
               next_state = RESULT;
               cmp_load   = 1'b1;
            end
         end
         RESULT: begin
            compare = 1'b1;
            if (invalid_password || cmp_done) begin
               fail_event = 1'b1;
               next_state = CHECK;
            end else if (correct_password) begin
               correct_event = 1'b1;
               next_state    = IDLE;
            end
         end
         CHECK: begin
            if (fail_cnt == MAX_A) begin
               next_state = LOCKOUT;
               lock_load  = 1'b1;
            end else begin
               next_state = IDLE;
            end
         end
         LOCKOUT: begin
            locked = 1'b1;
            if (lock_done) next_state = IDLE;
         end
         STORE: begin
            store_value = 1'b1;
            if (!store_button) next_state = WAIT_ST;
         end
         WAIT_ST: begin
            if (store_button)       next_state = STORE;
            else if (submit_button) next_state = STORE_PW;
         end
         STORE_PW: begin
            if (!submit_button) next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Registered flag and remaining-attempt count
   always_comb begin
      unlock_pulse  = unlock_q;
      attempts_left = MAX_A - fail_cnt;
   end

endmodule

// File: tb/tb_lock_ctrl_fsm.sv
// tb/tb_lock_ctrl_fsm.sv - self-checking bench for lock_ctrl_fsm
module tb_lock_ctrl_fsm;

   localparam int MAX_A = 3;
   localparam int LCK   = 10;
   localparam int CMPT  = 4;

   logic       clk = 1'b0;
   logic       system_reset = 1'b1;
   logic       input_button = 1'b0, store_button = 1'b0, submit_button = 1'b0;
   logic       correct_password = 1'b0, invalid_password = 1'b0;
   logic       input_value, store_value, compare, unlock_pulse, locked;
   logic [3:0] attempts_left;

   always #5 clk = ~clk;

   lock_ctrl_fsm #(
      .MAX_ATTEMPTS   (MAX_A),
      .LOCKOUT_CYCLES (LCK),
      .CMP_TIMEOUT    (CMPT),
      .CNT_W          (32)
   ) dut (
      .clk              (clk),
      .system_reset     (system_reset),
      .input_button     (input_button),
      .store_button     (store_button),
      .submit_button    (submit_button),
      .correct_password (correct_password),
      .invalid_password (invalid_password),
      .input_value      (input_value),
      .store_value      (store_value),
      .compare          (compare),
      .unlock_pulse     (unlock_pulse),
      .locked           (locked),
      .attempts_left    (attempts_left)
   );

   typedef struct {
      logic       rst, ib, sb, sub, cor, inv;
      logic [8:0] exp;
      string      name;
   } vec_t;

   typedef struct {
      logic [8:0] exp;
      string      name;
   } sb_t;

   sb_t  sb_q[$];
   vec_t tbl[$];
   int   total = 0;
   int   bad   = 0;
   int   fails = 0;

   // expected output word {input_value, store_value, compare, unlock_pulse, locked, attempts_left}
   function automatic logic [8:0] o(input logic iv, input logic sv, input logic cm,
                                    input logic un, input logic lk, input int att);
      return {iv, sv, cm, un, lk, 4'(att)};
   endfunction

   function automatic vec_t mk(input logic rst, input logic ib, input logic sb, input logic sub,
                               input logic cor, input logic inv, input logic [8:0] exp,
                               input string name);
      vec_t v;
      v.rst = rst; v.ib = ib; v.sb = sb; v.sub = sub; v.cor = cor; v.inv = inv;
      v.exp = exp; v.name = name;
      return v;
   endfunction

   // apply one cycle of inputs and queue the outputs expected after the next edge
   task automatic drive(input logic rst, input logic ib, input logic sb, input logic sub,
                        input logic cor, input logic inv, input logic [8:0] exp,
                        input string name);
      sb_t e;
      @(negedge clk);
      system_reset     = rst;
      input_button     = ib;
      store_button     = sb;
      submit_button    = sub;
      correct_password = cor;
      invalid_password = inv;
      e.exp  = exp;
      e.name = name;
      sb_q.push_back(e);
   endtask

   // compare DUT outputs against the scoreboard one step after each rising edge
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            sb_t e;
            logic [8:0] got;
            e   = sb_q.pop_front();
            got = {input_value, store_value, compare, unlock_pulse, locked, attempts_left};
            total++;
            if (got !== e.exp) begin
               bad++;
               $display("FAIL %s: got iv/sv/cmp/unl/lck=%b att=%0d, want iv/sv/cmp/unl/lck=%b att=%0d",
                        e.name, got[8:4], got[3:0], e.exp[8:4], e.exp[3:0]);
            end
         end
      end
   end

   function automatic int att_now();
      return MAX_A - fails;
   endfunction

   // walk from IDLE into RESULT
   task automatic to_result();
      drive(0, 1, 0, 0, 0, 0, o(1, 0, 0, 0, 0, att_now()), "rnd_input");
      drive(0, 0, 0, 0, 0, 0, o(0, 0, 0, 0, 0, att_now()), "rnd_wait_in");
      drive(0, 0, 0, 1, 0, 0, o(0, 0, 1, 0, 0, att_now()), "rnd_compare");
      drive(0, 0, 0, 0, 0, 0, o(0, 0, 1, 0, 0, att_now()), "rnd_result");
   endtask

   // one invalid round; stops in CHECK when the limit is reached
   task automatic fail_round();
      to_result();
      if (fails < MAX_A) fails++;
      drive(0, 0, 0, 0, 0, 1, o(0, 0, 0, 0, 0, att_now()), "rnd_check");
      if (fails < MAX_A)
         drive(0, 0, 0, 0, 0, 0, o(0, 0, 0, 0, 0, att_now()), "rnd_back_idle");
   endtask

   task automatic good_round();
      to_result();
      fails = 0;
      drive(0, 0, 0, 0, 1, 0, o(0, 0, 0, 1, 0, MAX_A), "rnd_unlock");
      drive(0, 0, 0, 0, 0, 0, o(0, 0, 0, 0, 0, MAX_A), "rnd_unlock_clear");
   endtask

   // from CHECK: locked for exactly n cycles with noise on every input, then IDLE
   task automatic lockout_check(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         drive(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               o(0, 0, 0, 0, 1, 0), tag);
      end
      fails = 0;
      drive(0, 0, 0, 0, 0, 0, o(0, 0, 0, 0, 0, MAX_A), {tag, "_exit"});
   endtask

   initial begin
      // entry/compare success, simultaneous events, store path
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 3), "reset_state"));
      tbl.push_back(mk(0, 1, 0, 0, 0, 0, o(1, 0, 0, 0, 0, 3), "input_c1"));
      tbl.push_back(mk(0, 1, 0, 0, 0, 0, o(1, 0, 0, 0, 0, 3), "input_c2"));
      tbl.push_back(mk(0, 1, 0, 0, 0, 0, o(1, 0, 0, 0, 0, 3), "input_c3"));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 3), "wait_in"));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, o(0, 0, 1, 0, 0, 3), "compare_c1"));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, o(0, 0, 1, 0, 0, 3), "compare_c2"));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, o(0, 0, 1, 0, 0, 3), "result_c1"));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, o(0, 0, 1, 0, 0, 3), "result_c2"));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, o(0, 0, 0, 1, 0, 3), "unlock_pulse"));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 3), "unlock_one_cycle"));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, o(0, 0, 0, 0, 0, 3), "idle_submit_ignored"));
      tbl.push_back(mk(0, 1, 1, 0, 0, 0, o(1, 0, 0, 0, 0, 3), "input_over_store"));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 3), "wait_in_2"));
      tbl.push_back(mk(0, 1, 0, 0, 0, 0, o(1, 0, 0, 0, 0, 3), "reenter_input"));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 3), "wait_in_3"));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, o(0, 0, 1, 0, 0, 3), "compare_2"));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, o(0, 0, 1, 0, 0, 3), "result_2"));
      tbl.push_back(mk(0, 0, 0, 0, 1, 1, o(0, 0, 0, 0, 0, 2), "both_verdicts_fail"));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 2), "both_no_unlock"));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, o(0, 1, 0, 0, 0, 2), "store_c1"));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, o(0, 1, 0, 0, 0, 2), "store_c2"));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 2), "wait_st"));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, o(0, 1, 0, 0, 0, 2), "reenter_store"));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 2), "wait_st_2"));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, o(0, 0, 0, 0, 0, 2), "store_pw_c1"));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, o(0, 0, 0, 0, 0, 2), "store_pw_c2"));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 2), "store_pw_idle"));
      tbl.push_back(mk(0, 1, 0, 0, 0, 0, o(1, 0, 0, 0, 0, 2), "idle_after_store"));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 2), "wait_in_4"));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, o(0, 0, 0, 0, 0, 3), "reset_restores"));

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].rst, tbl[i].ib, tbl[i].sb, tbl[i].sub, tbl[i].cor, tbl[i].inv,
               tbl[i].exp, tbl[i].name);
      end
      fails = 0;

      // compare timeout: RESULT holds for CMPT cycles, then counts a failure
      to_result();
      for (int i = 1; i < CMPT; i++)
         drive(0, 0, 0, 0, 0, 0, o(0, 0, 1, 0, 0, MAX_A), "timeout_wait");
      fails = 1;
      drive(0, 0, 0, 0, 0, 0, o(0, 0, 0, 0, 0, att_now()), "timeout_fail");
      drive(0, 0, 0, 0, 0, 0, o(0, 0, 0, 0, 0, att_now()), "timeout_idle");
      fails = 0;
      drive(1, 0, 0, 0, 0, 0, o(0, 0, 0, 0, 0, MAX_A), "reset_after_timeout");

      // lockout after MAX_A failures
      for (int r = 0; r < MAX_A; r++) fail_round();
      lockout_check(LCK, "lockout");
      drive(0, 0, 0, 0, 0, 0, o(0, 0, 0, 0, 0, MAX_A), "post_lockout_idle");

      // reset during LOCKOUT
      for (int r = 0; r < MAX_A; r++) fail_round();
      for (int i = 0; i < 3; i++)
         drive(0, 0, 0, 0, 0, 0, o(0, 0, 0, 0, 1, 0), "pre_reset_locked");
      fails = 0;
      drive(1, 1, 0, 0, 0, 0, o(0, 0, 0, 0, 0, MAX_A), "reset_in_lockout");
      drive(0, 0, 0, 0, 0, 0, o(0, 0, 0, 0, 0, MAX_A), "after_reset_lockout");

      // reset during RESULT, with a correct verdict racing it
      fail_round();
      to_result();
      fails = 0;
      drive(1, 0, 0, 0, 1, 0, o(0, 0, 0, 0, 0, MAX_A), "reset_in_result");
      drive(0, 0, 0, 0, 0, 0, o(0, 0, 0, 0, 0, MAX_A), "after_reset_result");

`ifdef LOCK_ESCALATE_EN
      begin
         int lens[5];
         lens = '{LCK, 2 * LCK, 4 * LCK, 8 * LCK, 8 * LCK};
         for (int k = 0; k < 5; k++) begin
            for (int r = 0; r < MAX_A; r++) fail_round();
            lockout_check(lens[k], $sformatf("esc_lock%0d", k));
         end
         good_round();
         for (int r = 0; r < MAX_A; r++) fail_round();
         lockout_check(LCK, "esc_after_unlock");
      end
`endif

      @(posedge clk);
      #2;
      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
